// File: rtl/riscv_fetch_unit_pkg.sv
// riscv_fetch_unit_pkg: shared constants and fetch buffer entry type
package riscv_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer: synchronous FIFO of fetched words with flush and occupancy count
module riscv_fetch_buffer
  import riscv_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           din,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign head = mem[rd];
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: PC, imem request/response tracking and fetch buffer; RISCV_FETCH_ALIGN_CHECK_EN enables misaligned-redirect halt
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter int WORD_LENGTH = XLEN,
  parameter logic [WORD_LENGTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WORD_LENGTH-1:0] imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [WORD_LENGTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [WORD_LENGTH-1:0] inst,
  output logic [WORD_LENGTH-1:0] inst_pc,
  output logic                   fetch_misaligned
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  logic rst_hold, halted, req_fire, push, pop, tgt_bad;
  logic [WORD_LENGTH-1:0] pc, rsp_pc, tgt;
  logic [CW-1:0] inflight, inflight_next, drop_cnt, count;
  fetch_entry_t head, rsp_entry;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  assign tgt = redirect_pc;
  assign tgt_bad = |redirect_pc[1:0];
`else
  assign tgt = {redirect_pc[WORD_LENGTH-1:2], 2'b00};
  assign tgt_bad = 1'b0;
`endif
  assign imem_req_valid = !rst_hold && !halted && (inflight + count < DEPTH_C);
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign rsp_entry = '{inst: imem_rsp_data, pc: rsp_pc};
  assign inst = inst_valid ? head.inst : (rst_hold ? '0 : INST_NOP);
  assign inst_pc = inst_valid ? head.pc : '0;
  assign fetch_misaligned = halted;
  riscv_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .din(rsp_entry),
    .pop(pop),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    rst_hold <= rst;
    if (rst) begin
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      halted <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        pc <= tgt;
        rsp_pc <= tgt;
        drop_cnt <= inflight_next;
        halted <= tgt_bad;
      end else begin
        if (req_fire) pc <= pc + WORD_LENGTH'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) rsp_pc <= rsp_pc + WORD_LENGTH'(4);
      end
    end
  end
endmodule
